rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single regfile write port between NREQ writeback sources (EXU, LSU, MDU) with round-robin arbitration.
//  Registers the winner onto the regfile write port, one write per cycle.
//  Keeps a per-register busy scoreboard that decode uses for RAW-hazard stalls.
//  Sits between the writeback sources and regfile; decode reads its hazard outputs.
// PARAMETERS
//  NREQ  3  number of writeback requesters (>=2)
//  Data width `CPU_WIDTH, address width `REG_ADDRW and register count `REG_COUNT come from config.sv.
// PORTS
//  i_clk         in   1                  clock
//  i_rst_n       in   1                  synchronous reset, active-low
//  i_wb_valid    in   NREQ               requester i has a write pending
//  o_wb_ready    out  NREQ               one-hot grant; the request is accepted when valid&ready
//  i_wb_waddr    in   NREQ*`REG_ADDRW    per-requester destination, packed, requester 0 in LSBs
//  i_wb_wdata    in   NREQ*`CPU_WIDTH    per-requester write data, packed
//  o_rf_wen      out  1                  regfile write enable
//  o_rf_waddr    out  `REG_ADDRW         regfile write address
//  o_rf_wdata    out  `CPU_WIDTH         regfile write data
//  i_iss_valid   in   1                  an instruction with rd is issued this cycle
//  i_iss_rd      in   `REG_ADDRW         destination of the issued instruction
//  i_raddr1/2    in   `REG_ADDRW         decode source registers
//  o_hazard1/2   out  1                  the source has a write in flight; decode must stall
//  o_fwd1/2_vld  out  1                  forward data is valid for the source (bypass build only)
//  o_fwd1/2_data out  `CPU_WIDTH         forward data
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge):
//   - o_rf_wen=0, o_rf_waddr=0, o_rf_wdata=0
//   - all busy bits = 0; rr_ptr = 0
//   - reset mid-operation discards any request not yet registered
//  Arbitration (combinational):
//   - Scan valid requesters from rr_ptr upward, modulo NREQ; the first valid one is granted.
//   - o_wb_ready is one-hot or zero, and depends only on i_wb_valid and rr_ptr.
//   - On a grant to index g, rr_ptr <= (g+1) mod NREQ. With no valid requester, rr_ptr holds.
//  Write port:
//   - Latency is 1 cycle: the request accepted in cycle N drives o_rf_* during cycle N+1 and is written at the end of N+1.
//   - No backpressure: one request is accepted every cycle in which any requester is valid.
//   - waddr==0 is accepted but o_rf_wen=0; x0 is never written.
//   - With no grant, o_rf_wen=0 and addr/data hold their previous values.
//  Scoreboard, busy[`REG_COUNT]:
//   - set: i_iss_valid && i_iss_rd!=0 sets busy[i_iss_rd] at the next edge.
//   - clear: o_rf_wen clears busy[o_rf_waddr] at the end of the commit cycle.
//   - set and clear of the same register in the same cycle: set wins.
//   - busy[0] is always 0.
//   - Issuing to an already busy rd is legal; the bit simply stays set (decode serialises WAW).
//  Hazard:
//   - base rule: o_hazardK = busy[i_raddrK] for K=1,2; raddr 0 never signals a hazard.
// CONFIGURATION
//  Macro WBARB_BYPASS_EN.
//  Defined:
//   - o_fwdK_vld = o_rf_wen && o_rf_waddr==i_raddrK && i_raddrK!=0
//   - o_fwdK_data = o_rf_wdata
//   - o_hazardK = busy[i_raddrK] && !o_fwdK_vld, which removes the 1-cycle read-during-write stall.
//  Undefined:
//   - o_fwdK_vld=0 and o_fwdK_data=0
//   - o_hazardK = busy[i_raddrK], so decode waits until the cycle after the commit.
// STRUCTURE
//  Shared package wb_pkg:
//   - typedef wb_req_t {logic [`REG_ADDRW-1:0] waddr; logic [`CPU_WIDTH-1:0] wdata;}
//   - localparam for requester indices: WB_EXU=0, WB_LSU=1, WB_MDU=2
//  One sub-module rr_arb #(N) (req, ptr -> one-hot gnt, gnt_idx), reusable for the LSU bus arbiter.
//  Write register, rr_ptr and scoreboard live in rf_wb_arbiter.
// TESTING
//  1. Reset, then single write: valid[0], waddr=5, wdata=0xDEAD.
//     -> ready[0] the same cycle; next cycle wen=1, waddr=5, wdata=0xDEAD.
//  2. All three valid for 3 cycles with rr_ptr=0.
//     -> grants 0,1,2 in order; rr_ptr returns to 0; writes appear on cycles 2,3,4.
//  3. Write to x0 with wdata=0xFFFF.
//     -> ready asserted; o_rf_wen stays 0; busy unchanged.
//  4. Issue rd=7, then commit waddr=7 three cycles later, with raddr1=7 throughout.
//     -> hazard1 high from issue+1; it drops in the commit cycle with bypass (fwd1_vld=1, data matches), or on commit+1 without.
//  5. Issue rd=9 in the same cycle that o_rf_waddr=9 commits.
//     -> busy[9] remains 1 (set wins).
//  6. Assert i_rst_n=0 for 1 cycle with requests pending and busy bits set.
//     -> o_rf_wen=0, all hazards 0, rr_ptr=0 on the next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback package: widths taken from the core configuration,
// the per-requester writeback record, requester indices and a small
// modulo helper used by the round-robin logic.
// The fallback defines below keep the package self-contained when
// config.sv is not compiled ahead of it; config.sv wins when it is.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

package wb_pkg;

    localparam int CPU_W   = `CPU_WIDTH;
    localparam int REG_AW  = `REG_ADDRW;
    localparam int REG_CNT = `REG_COUNT;

    localparam int WB_EXU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;

    typedef struct packed {
        logic [`REG_ADDRW-1:0] waddr;
        logic [`CPU_WIDTH-1:0] wdata;
    } wb_req_t;

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/config.sv
// Core-wide configuration macros shared by the CPU blocks.
//   CPU_WIDTH  data path width in bits
//   REG_ADDRW  register address width in bits
//   REG_COUNT  number of architectural registers (2**REG_ADDRW)
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

// File: rtl/rf_wb_arbiter_rr_arb.sv
// rr_arb: combinational round-robin arbiter.
// Scans req starting at index ptr, wrapping modulo N, and grants the
// first asserted request.
//   req     in  N        request vector
//   ptr     in  IW       index with highest priority this cycle
//   gnt     out N        one-hot grant, zero when no request
//   gnt_idx out IW       index of the granted request (0 when none)
module rr_arb
    import wb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]                      req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
    output logic [N-1:0]                      gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic found_s;

    // Priority scan from ptr upward; the first hit wins.
    always_comb begin
        int cand;
        gnt     = {N{1'b0}};
        gnt_idx = {IW{1'b0}};
        found_s = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = rr_wrap(int'(ptr), k, N);
            if (!found_s && req[IW'(cand)]) begin
                found_s          = 1'b1;
                gnt[IW'(cand)]   = 1'b1;
                gnt_idx          = IW'(cand);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single regfile write port between NREQ
// writeback sources with round-robin arbitration, registers the winner
// onto the write port and keeps the per-register busy scoreboard that
// decode uses for RAW-hazard stalls.
// Optional feature macro: WBARB_BYPASS_EN (forward the committing write
// to decode sources instead of stalling for one more cycle).
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_wb_valid / o_wb_ready        per-requester request / one-hot grant
//   i_wb_waddr / i_wb_wdata        packed per-requester destination/data
//   o_rf_wen/waddr/wdata           registered regfile write port
//   i_iss_valid / i_iss_rd         issue of an instruction writing rd
//   i_raddr1/2                     decode source registers
//   o_hazard1/2                    source has a write in flight
//   o_fwd1/2_vld, o_fwd1/2_data    forwarded commit data (bypass build)
module rf_wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_wb_valid,
    output logic [NREQ-1:0]        o_wb_ready,
    input  logic [NREQ*REG_AW-1:0] i_wb_waddr,
    input  logic [NREQ*CPU_W-1:0]  i_wb_wdata,
    output logic                   o_rf_wen,
    output logic [REG_AW-1:0]      o_rf_waddr,
    output logic [CPU_W-1:0]       o_rf_wdata,
    input  logic                   i_iss_valid,
    input  logic [REG_AW-1:0]      i_iss_rd,
    input  logic [REG_AW-1:0]      i_raddr1,
    input  logic [REG_AW-1:0]      i_raddr2,
    output logic                   o_hazard1,
    output logic                   o_hazard2,
    output logic                   o_fwd1_vld,
    output logic [CPU_W-1:0]       o_fwd1_data,
    output logic                   o_fwd2_vld,
    output logic [CPU_W-1:0]       o_fwd2_data
);

    localparam int IW = $clog2(NREQ);

    wb_req_t             req_s [NREQ];
    logic [NREQ-1:0]     gnt_s;
    logic [IW-1:0]       gnt_idx_s;
    logic                gnt_any_s;
    wb_req_t             win_s;
    logic [IW-1:0]       rr_ptr_nxt_s;
    logic [REG_CNT-1:0]  busy_nxt_s;

    logic [IW-1:0]       rr_ptr_r;
    logic                rf_wen_r;
    logic [REG_AW-1:0]   rf_waddr_r;
    logic [CPU_W-1:0]    rf_wdata_r;
    logic [REG_CNT-1:0]  busy_r;

    // Unpack the flat requester buses into records, requester 0 in the LSBs.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_s[i].waddr = i_wb_waddr[i*REG_AW +: REG_AW];
        assign req_s[i].wdata = i_wb_wdata[i*CPU_W +: CPU_W];
    end

    rr_arb #(.N(NREQ)) u_rr_arb (
        .req     (i_wb_valid),
        .ptr     (rr_ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign o_wb_ready   = gnt_s;
    assign gnt_any_s    = |gnt_s;
    assign win_s        = req_s[gnt_idx_s];
    assign rr_ptr_nxt_s = IW'(rr_wrap(int'(gnt_idx_s), 1, NREQ));

    // Scoreboard update: the committing write clears, a new issue sets and
    // is applied last so it wins on the same register; x0 is never busy.
    always_comb begin
        busy_nxt_s = busy_r;
        if (rf_wen_r) begin
            busy_nxt_s[rf_waddr_r] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (i_iss_valid && (i_iss_rd != {REG_AW{1'b0}})) begin
            busy_nxt_s[i_iss_rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Pointer, write-port register and scoreboard state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr_r   <= {IW{1'b0}};
            rf_wen_r   <= 1'b0;
            rf_waddr_r <= {REG_AW{1'b0}};
            rf_wdata_r <= {CPU_W{1'b0}};
            busy_r     <= {REG_CNT{1'b0}};
        end else begin
            if (gnt_any_s) begin
                rr_ptr_r   <= rr_ptr_nxt_s;
                // A write to x0 is accepted but never enabled.
                rf_wen_r   <= (win_s.waddr != {REG_AW{1'b0}});
                rf_waddr_r <= win_s.waddr;
                rf_wdata_r <= win_s.wdata;
            end else begin
                rf_wen_r   <= 1'b0;
            end
            busy_r <= busy_nxt_s;
        end
    end

    assign o_rf_wen   = rf_wen_r;
    assign o_rf_waddr = rf_waddr_r;
    assign o_rf_wdata = rf_wdata_r;

`ifdef WBARB_BYPASS_EN
    // The committing write is visible to decode in its commit cycle.
    assign o_fwd1_vld  = rf_wen_r && (rf_waddr_r == i_raddr1) && (i_raddr1 != {REG_AW{1'b0}});
    assign o_fwd2_vld  = rf_wen_r && (rf_waddr_r == i_raddr2) && (i_raddr2 != {REG_AW{1'b0}});
    assign o_fwd1_data = rf_wdata_r;
    assign o_fwd2_data = rf_wdata_r;
    assign o_hazard1   = busy_r[i_raddr1] && !o_fwd1_vld;
    assign o_hazard2   = busy_r[i_raddr2] && !o_fwd2_vld;
`else
    assign o_fwd1_vld  = 1'b0;
    assign o_fwd2_vld  = 1'b0;
    assign o_fwd1_data = {CPU_W{1'b0}};
    assign o_fwd2_data = {CPU_W{1'b0}};
    assign o_hazard1   = busy_r[i_raddr1];
    assign o_hazard2   = busy_r[i_raddr2];
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (both bypass and default builds).
module tb_rf_wb_arbiter;
    import wb_pkg::*;

    localparam int NREQ = 3;

    logic                   i_clk;
    logic                   i_rst_n;
    logic [NREQ-1:0]        i_wb_valid;
    logic [NREQ-1:0]        o_wb_ready;
    logic [NREQ*REG_AW-1:0] i_wb_waddr;
    logic [NREQ*CPU_W-1:0]  i_wb_wdata;
    logic                   o_rf_wen;
    logic [REG_AW-1:0]      o_rf_waddr;
    logic [CPU_W-1:0]       o_rf_wdata;
    logic                   i_iss_valid;
    logic [REG_AW-1:0]      i_iss_rd;
    logic [REG_AW-1:0]      i_raddr1;
    logic [REG_AW-1:0]      i_raddr2;
    logic                   o_hazard1;
    logic                   o_hazard2;
    logic                   o_fwd1_vld;
    logic [CPU_W-1:0]       o_fwd1_data;
    logic                   o_fwd2_vld;
    logic [CPU_W-1:0]       o_fwd2_data;

    int errors_r = 0;
    int checks_r = 0;

    rf_wb_arbiter #(.NREQ(NREQ)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wb_valid  (i_wb_valid),
        .o_wb_ready  (o_wb_ready),
        .i_wb_waddr  (i_wb_waddr),
        .i_wb_wdata  (i_wb_wdata),
        .o_rf_wen    (o_rf_wen),
        .o_rf_waddr  (o_rf_waddr),
        .o_rf_wdata  (o_rf_wdata),
        .i_iss_valid (i_iss_valid),
        .i_iss_rd    (i_iss_rd),
        .i_raddr1    (i_raddr1),
        .i_raddr2    (i_raddr2),
        .o_hazard1   (o_hazard1),
        .o_hazard2   (o_hazard2),
        .o_fwd1_vld  (o_fwd1_vld),
        .o_fwd1_data (o_fwd1_data),
        .o_fwd2_vld  (o_fwd2_vld),
        .o_fwd2_data (o_fwd2_data)
    );

    // 10-unit clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [REG_AW-1:0] a, input logic [CPU_W-1:0] d);
        i_wb_waddr[idx*REG_AW +: REG_AW] = a;
        i_wb_wdata[idx*CPU_W +: CPU_W]   = d;
    endtask

    // Stimulus and checks.
    initial begin
        i_rst_n     = 1'b0;
        i_wb_valid  = 3'b000;
        i_wb_waddr  = '0;
        i_wb_wdata  = '0;
        i_iss_valid = 1'b0;
        i_iss_rd    = 5'd0;
        i_raddr1    = 5'd5;
        i_raddr2    = 5'd0;
        tick();
        tick();
        i_rst_n = 1'b1;
        #1;
        chk("rst_wen",   64'(o_rf_wen),   64'd0);
        chk("rst_waddr", 64'(o_rf_waddr), 64'd0);
        chk("rst_wdata", 64'(o_rf_wdata), 64'd0);
        chk("rst_haz1",  64'(o_hazard1),  64'd0);
        chk("rst_ready", 64'(o_wb_ready), 64'd0);

        // 1: single write from requester 0.
        set_req(WB_EXU, 5'd5, 32'hDEAD);
        i_wb_valid = 3'b001;
        #1;
        chk("t1_ready", 64'(o_wb_ready), 64'd1);
        tick();
        i_wb_valid = 3'b000;
        #1;
        chk("t1_wen",   64'(o_rf_wen),   64'd1);
        chk("t1_waddr", 64'(o_rf_waddr), 64'd5);
        chk("t1_wdata", 64'(o_rf_wdata), 64'hDEAD);
        chk("t1_idle_ready", 64'(o_wb_ready), 64'd0);
        tick();
        chk("t1_hold_wen",   64'(o_rf_wen),   64'd0);
        chk("t1_hold_waddr", 64'(o_rf_waddr), 64'd5);
        chk("t1_hold_wdata", 64'(o_rf_wdata), 64'hDEAD);

        // 2: pointer is 1; a lone grant to 2 brings it back to 0.
        set_req(WB_MDU, 5'd3, 32'h333);
        i_wb_valid = 3'b100;
        #1;
        chk("t2_pre_ready", 64'(o_wb_ready), 64'd4);
        tick();
        chk("t2_pre_waddr", 64'(o_rf_waddr), 64'd3);
        set_req(WB_EXU, 5'd1, 32'h111);
        set_req(WB_LSU, 5'd2, 32'h222);
        i_wb_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_ready", 64'(o_wb_ready), 64'(1 << k));
            tick();
            chk("t2_wen",   64'(o_rf_wen),   64'd1);
            chk("t2_waddr", 64'(o_rf_waddr), 64'(k + 1));
            chk("t2_wdata", 64'(o_rf_wdata), 64'(32'h111 * (k + 1)));
        end
        chk("t2_ptr_wrap", 64'(o_wb_ready), 64'd1);
        i_wb_valid = 3'b000;
        tick();

        // 3: write to x0 is accepted but not enabled (pointer 0 -> grant 1).
        i_raddr1 = 5'd0;
        set_req(WB_LSU, 5'd0, 32'hFFFF);
        i_wb_valid = 3'b010;
        #1;
        chk("t3_ready", 64'(o_wb_ready), 64'd2);
        tick();
        i_wb_valid = 3'b000;
        #1;
        chk("t3_wen",  64'(o_rf_wen),  64'd0);
        chk("t3_haz0", 64'(o_hazard1), 64'd0);

        // 4: issue rd=7, commit three cycles later (pointer is 2).
        i_raddr1    = 5'd7;
        i_raddr2    = 5'd7;
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd7;
        #1;
        chk("t4_haz_pre", 64'(o_hazard1), 64'd0);
        tick();
        i_iss_valid = 1'b0;
        #1;
        chk("t4_haz1_i1", 64'(o_hazard1), 64'd1);
        chk("t4_haz2_i1", 64'(o_hazard2), 64'd1);
        tick();
        chk("t4_haz1_i2", 64'(o_hazard1), 64'd1);
        set_req(WB_EXU, 5'd7, 32'h7777);
        i_wb_valid = 3'b001;
        #1;
        chk("t4_ready", 64'(o_wb_ready), 64'd1);
        tick();
        i_wb_valid = 3'b000;
        #1;
        chk("t4_commit_wen", 64'(o_rf_wen), 64'd1);
`ifdef WBARB_BYPASS_EN
        chk("t4_commit_haz1", 64'(o_hazard1),   64'd0);
        chk("t4_commit_haz2", 64'(o_hazard2),   64'd0);
        chk("t4_fwd1_vld",    64'(o_fwd1_vld),  64'd1);
        chk("t4_fwd1_data",   64'(o_fwd1_data), 64'h7777);
        chk("t4_fwd2_vld",    64'(o_fwd2_vld),  64'd1);
`else
        chk("t4_commit_haz1", 64'(o_hazard1),   64'd1);
        chk("t4_commit_haz2", 64'(o_hazard2),   64'd1);
        chk("t4_fwd1_vld",    64'(o_fwd1_vld),  64'd0);
        chk("t4_fwd1_data",   64'(o_fwd1_data), 64'd0);
`endif
        tick();
        chk("t4_post_haz1", 64'(o_hazard1),  64'd0);
        chk("t4_post_fwd1", 64'(o_fwd1_vld), 64'd0);

        // 5: re-issue rd=9 in its commit cycle; set wins (pointer is 1).
        i_raddr1    = 5'd9;
        i_raddr2    = 5'd0;
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd9;
        tick();
        i_iss_valid = 1'b0;
        set_req(WB_LSU, 5'd9, 32'h9999);
        i_wb_valid = 3'b010;
        #1;
        chk("t5_ready", 64'(o_wb_ready), 64'd2);
        chk("t5_haz1",  64'(o_hazard1),  64'd1);
        tick();
        i_wb_valid  = 3'b000;
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd9;
        #1;
        chk("t5_commit_waddr", 64'(o_rf_waddr), 64'd9);
        tick();
        i_iss_valid = 1'b0;
        #1;
        chk("t5_set_wins", 64'(o_hazard1), 64'd1);

        // 6: reset with pending requests and busy bits (pointer is 2).
        i_raddr2    = 5'd12;
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd12;
        tick();
        i_iss_valid = 1'b0;
        #1;
        chk("t6_pre_haz2", 64'(o_hazard2), 64'd1);
        set_req(WB_EXU, 5'd4, 32'h4444);
        set_req(WB_LSU, 5'd5, 32'h5555);
        set_req(WB_MDU, 5'd6, 32'h6666);
        i_wb_valid = 3'b111;
        i_rst_n    = 1'b0;
        tick();
        i_rst_n = 1'b1;
        #1;
        chk("t6_wen",   64'(o_rf_wen),   64'd0);
        chk("t6_haz1",  64'(o_hazard1),  64'd0);
        chk("t6_haz2",  64'(o_hazard2),  64'd0);
        chk("t6_ptr0",  64'(o_wb_ready), 64'd1);
        i_wb_valid = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
